ifft64_seq_ctrl: RTL and testbench



---
 rtl/ifft64_pkg.sv | 39 +++
 rtl/ifft64_stage_phase.sv | 53 +++++
 rtl/ifft64_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_ifft64_seq_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifft64_pkg.sv
// Shared types and constants for the 64-point radix-2 MDC IFFT sequencer.
// Holds the run-FSM state enum, frame/stage geometry and the helpers that
// turn the per-stage phase counters into commutator and twiddle controls.
package ifft64_pkg;

  localparam int FRAME_CYC  = 32;
  localparam int LOG2_FRAME = 5;
  localparam int N_STAGES   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [N_STAGES-1:0][LOG2_FRAME-1:0] phase_vec_t;

  // Stage k twiddle address is (p_k << k) mod 32; stage 5 needs no twiddle.
  function automatic logic [N_STAGES*LOG2_FRAME-1:0] pack_tw(input phase_vec_t ph);
    logic [N_STAGES*LOG2_FRAME-1:0] tw;
    tw = '0;
    for (int k = 0; k < N_STAGES - 1; k++) begin
      tw[k*LOG2_FRAME +: LOG2_FRAME] = LOG2_FRAME'(ph[k] << k);
    end
    return tw;
  endfunction

  // Commutator of stage k follows bit (5-k) of its phase; stage 0 has none.
  function automatic logic [N_STAGES-1:0] sw_sel(input phase_vec_t ph);
    logic [N_STAGES-1:0] sw;
    sw = '0;
    for (int k = 1; k < N_STAGES; k++) begin
      sw[k] = ph[k][LOG2_FRAME-k];
    end
    return sw;
  endfunction

endpackage

// File: rtl/ifft64_stage_phase.sv
// Per-stage control: delays the incoming valid by DLY cycles and runs the
// 5-bit phase counter that advances on every valid cycle of this stage.
// The phase returns to 0 whenever the stage is idle so every frame starts aligned.
module ifft64_stage_phase
  import ifft64_pkg::*;
#(
  parameter int DLY = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_vld,
  output logic                  o_vld,
  output logic [LOG2_FRAME-1:0] o_phase
);

  logic                  w_vld;
  logic [LOG2_FRAME-1:0] r_phase;

  generate
    if (DLY == 0) begin : g_nodly
      assign w_vld = i_vld;
    end else begin : g_dly
      logic [DLY-1:0] r_dly;
      // Valid delay line matching the butterfly register latency.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= i_vld;
          for (int i = 1; i < DLY; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end
      assign w_vld = r_dly[DLY-1];
    end
  endgenerate

  // Phase counter: counts valid cycles modulo 32, cleared while idle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_phase <= '0;
    end else if (w_vld) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  assign o_vld   = w_vld;
  assign o_phase = r_phase;

endmodule

// File: rtl/ifft64_seq_ctrl.sv
// Run sequencer for the 64-point MDC IFFT: walks the input bank, drives the
// per-stage valid/commutator/twiddle controls and flags the output window.
// Latency: first start_check PIPE_LAT+1 cycles after start; done one cycle after the last.
module ifft64_seq_ctrl
  import ifft64_pkg::*;
#(
  parameter int N_FRAMES  = 1000,
  parameter int STAGE_LAT = 2,
  parameter int PIPE_LAT  = 40
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  output logic [9:0]  bank_addr,
  output logic        in_valid,
  output logic [4:0]  in_cyc,
  output logic [5:0]  stg_valid,
  output logic [5:0]  sw_ctrl,
  output logic [29:0] tw_addr,
  output logic        start_check,
  output logic        busy,
  output logic        done
);

  localparam logic [9:0]  LAST_BANK = 10'(N_FRAMES - 1);
  localparam logic [4:0]  LAST_CYC  = 5'(FRAME_CYC - 1);
  localparam logic [14:0] LAST_OUT  = 15'(N_FRAMES * FRAME_CYC - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_in_valid;
  logic          r_busy;
  logic          r_done;
  logic [9:0]    r_bank_addr;
  logic [4:0]    r_in_cyc;
  logic [14:0]   r_out_cnt;
  logic [PIPE_LAT-1:0] r_dly;
  logic          w_start_check;
  logic [5:0]    w_vin;
  logic [5:0]    w_stg_valid;
  phase_vec_t    w_phase;

  assign w_start_check = r_dly[PIPE_LAT-1];

  // Next-state logic: batch launch, end of input, end of output window, handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (r_bank_addr == LAST_BANK && r_in_cyc == LAST_CYC) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_start_check && r_out_cnt == LAST_OUT) w_state_nxt = ST_DONE;
      ST_DONE:  if (!start) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= ST_IDLE;
      r_in_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_valid <= (w_state_nxt == ST_RUN);
      r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  // Bank/frame and output counters; cleared in IDLE and when returning to it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_bank_addr <= '0;
      r_in_cyc    <= '0;
      r_out_cnt   <= '0;
    end else if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
      r_bank_addr <= '0;
      r_in_cyc    <= '0;
      r_out_cnt   <= '0;
    end else begin
      if (w_start_check) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      if (r_state == ST_RUN) begin
        r_in_cyc <= r_in_cyc + 1'b1;
        if (r_in_cyc == LAST_CYC && r_bank_addr != LAST_BANK) begin
          r_bank_addr <= r_bank_addr + 1'b1;
        end
      end else begin
        r_in_cyc <= '0;
      end
    end
  end

  // Output-window delay line: start_check is in_valid delayed PIPE_LAT cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= r_in_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_vin = {w_stg_valid[4:0], r_in_valid};

  genvar k;
  generate
    for (k = 0; k < N_STAGES; k++) begin : g_stage
      ifft64_stage_phase #(
        .DLY ((k == 0) ? 0 : STAGE_LAT)
      ) u_phase (
        .clk     (clk),
        .arst    (arst),
        .i_vld   (w_vin[k]),
        .o_vld   (w_stg_valid[k]),
        .o_phase (w_phase[k])
      );
    end
  endgenerate

  assign bank_addr   = r_bank_addr;
  assign in_valid    = r_in_valid;
  assign in_cyc      = r_in_cyc;
  assign stg_valid   = w_stg_valid;
  assign sw_ctrl     = sw_sel(w_phase);
  assign tw_addr     = pack_tw(w_phase);
  assign start_check = w_start_check;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_ifft64_seq_ctrl.sv
// Scoreboard bench for ifft64_seq_ctrl with N_FRAMES=2, STAGE_LAT=2, PIPE_LAT=40.
// Cycle index convention: the cycle right after rising edge T0 is T0+1.
// Stimulus pushes expected in_valid/start_check/done/control events; a monitor pops and compares.
module tb_ifft64_seq_ctrl;

  localparam int NF = 2;
  localparam int SL = 2;
  localparam int PL = 40;

  logic        clk;
  logic        arst;
  logic        start;
  logic [9:0]  bank_addr;
  logic        in_valid;
  logic [4:0]  in_cyc;
  logic [5:0]  stg_valid;
  logic [5:0]  sw_ctrl;
  logic [29:0] tw_addr;
  logic        start_check;
  logic        busy;
  logic        done;

  ifft64_seq_ctrl #(
    .N_FRAMES  (NF),
    .STAGE_LAT (SL),
    .PIPE_LAT  (PL)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .bank_addr   (bank_addr),
    .in_valid    (in_valid),
    .in_cyc      (in_cyc),
    .stg_valid   (stg_valid),
    .sw_ctrl     (sw_ctrl),
    .tw_addr     (tw_addr),
    .start_check (start_check),
    .busy        (busy),
    .done        (done)
  );

  typedef struct { int idx; int bank; int cyc; } in_exp_t;
  typedef struct { int idx; logic [5:0] sv; logic [5:0] sw; logic [29:0] tw; } ctl_exp_t;

  in_exp_t  q_in[$];
  ctl_exp_t q_ctl[$];
  int       q_sc[$];
  int       q_done[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   tcount   = 0;
  int   t0;
  logic done_q   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tcount <= tcount + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected controls at cycle idx for a batch launched at edge t_0 (2 frames, STAGE_LAT 2).
  function automatic ctl_exp_t ctl_at(input int t_0, input int idx);
    ctl_exp_t   c;
    int         j;
    logic [4:0] p;
    c.idx = idx; c.sv = '0; c.sw = '0; c.tw = '0;
    for (int k = 0; k < 6; k++) begin
      j = idx - (t_0 + 1) - 2 * k;
      if (j >= 0 && j < 64) begin
        c.sv[k] = 1'b1;
        p = 5'(j % 32);
      end else begin
        p = 5'd0;
      end
      if (k >= 1) c.sw[k] = p[5-k];
      if (k <= 4) c.tw[5*k +: 5] = 5'((int'(p) << k) % 32);
    end
    return c;
  endfunction

  task automatic launch();
    in_exp_t e;
    start = 1'b1;
    t0 = tcount + 1;
    for (int i = 0; i < 64; i++) begin
      e.idx = t0 + 1 + i; e.bank = i / 32; e.cyc = i % 32;
      q_in.push_back(e);
      q_sc.push_back(t0 + 1 + PL + i);
    end
    for (int i = 0; i < 80; i++) q_ctl.push_back(ctl_at(t0, t0 + 1 + i));
    q_done.push_back(t0 + 1 + PL + 64);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
  endtask

  // Monitor: compares each DUT event against the head of its expectation queue.
  always @(negedge clk) begin
    int       idx;
    in_exp_t  e;
    ctl_exp_t c;
    int       s;
    if (!arst) begin
      idx = tcount + 1;
      if (in_valid) begin
        if (q_in.size() == 0) chk("in_valid_unexpected", in_valid, 0);
        else begin
          e = q_in.pop_front();
          chk("in_valid_cycle", idx, e.idx);
          chk("bank_addr", bank_addr, e.bank);
          chk("in_cyc", in_cyc, e.cyc);
        end
      end
      if (start_check) begin
        if (q_sc.size() == 0) chk("start_check_unexpected", start_check, 0);
        else begin
          s = q_sc.pop_front();
          chk("start_check_cycle", idx, s);
        end
      end
      if (done && !done_q) begin
        if (q_done.size() == 0) chk("done_unexpected", done, 0);
        else begin
          s = q_done.pop_front();
          chk("done_rise_cycle", idx, s);
        end
      end
      done_q = done;
      if (q_ctl.size() > 0 && q_ctl[0].idx == idx) begin
        c = q_ctl.pop_front();
        chk("stg_valid", stg_valid, c.sv);
        chk("sw_ctrl", sw_ctrl, c.sw);
        chk("tw_addr", tw_addr, c.tw);
      end
    end
  end

  initial begin
    int cnt;
    arst  = 1'b1;
    start = 1'b0;
    // Reset / idle
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bank_addr, in_valid, in_cyc, stg_valid, sw_ctrl, tw_addr, start_check, busy, done}, 0);
    repeat (7) @(negedge clk);
    #2 arst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_outputs", {bank_addr, in_valid, in_cyc, stg_valid, sw_ctrl, tw_addr, start_check, busy, done}, 0);

    // Batch A, start held high through DONE
    launch();
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_run", busy, 1);
    wait_done();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("done_hold", done, 1);
      if (in_valid) cnt++;
    end
    chk("no_relaunch", cnt, 0);

    // Drop start one cycle, then relaunch batch B; start released mid-batch
    start = 1'b0;
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_bank", bank_addr, 0);
    launch();
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_drop_start_low", done, 0);
    chk("busy_after_done", busy, 0);

    // Batch C with reset at bank 1, in_cyc 7
    launch();
    repeat (2) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !(bank_addr == 10'd1 && in_cyc == 5'd7); i++) @(negedge clk);
    chk("midrun_reach", {bank_addr, in_cyc}, {10'd1, 5'd7});
    #2 arst = 1'b1;
    #1;
    chk("midrst_in_valid", in_valid, 0);
    chk("midrst_bank", bank_addr, 0);
    chk("midrst_in_cyc", in_cyc, 0);
    chk("midrst_stg_valid", stg_valid, 0);
    chk("midrst_sw_ctrl", sw_ctrl, 0);
    chk("midrst_tw_addr", tw_addr, 0);
    chk("midrst_flags", {start_check, busy, done}, 0);
    q_in.delete(); q_sc.delete(); q_ctl.delete(); q_done.delete();
    repeat (2) @(negedge clk);
    #2 arst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (start_check) cnt++;
    end
    chk("no_check_after_rst", cnt, 0);

    // Batch D: restart from bank 0 after the reset
    launch();
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    chk("q_in_empty", q_in.size(), 0);
    chk("q_sc_empty", q_sc.size(), 0);
    chk("q_done_empty", q_done.size(), 0);
    chk("q_ctl_empty", q_ctl.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
